// File: rtl/bcd_mult_sched_if.sv
// Requester/result bus for bcd_mult_sched: level requests with packed BCD operands,
// one-hot grant, and a valid/ready result channel tagged with the requester ID.
interface bcd_mult_sched_if #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
);
   logic [NREQ-1:0]   req;
   logic [NREQ*8-1:0] a_bcd;
   logic [NREQ*8-1:0] b_bcd;
   logic [NREQ-1:0]   gnt;
   logic              busy;
   logic              res_valid;
   logic              res_ready;
   logic [15:0]       res_bcd;
   logic [IDW-1:0]    res_id;
   logic              res_err;

   modport master (
      output req, a_bcd, b_bcd, res_ready,
      input  gnt, busy, res_valid, res_bcd, res_id, res_err
   );

   modport slave (
      input  req, a_bcd, b_bcd, res_ready,
      output gnt, busy, res_valid, res_bcd, res_id, res_err
   );
endinterface

// File: rtl/bcd_mult_sched.sv
// Round-robin scheduler sharing one BCD multiply engine (BCD->bin, 8x8 multiply, double-dabble back).
// Optional operand digit check enabled by defining BCD_MULT_SCHED_BCD_CHECK_EN.
//
// state | meaning
// IDLE  | arbitrate; grant winner, capture binary operands, ID and pointer
// MULT  | register 16-bit product, clear accumulator and shift counter
// CONV  | 16 shift-add-3 steps; last step loads the result registers
// OUT   | res_valid high, hold result until res_ready
module bcd_mult_sched #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input logic           clock,
   input logic           a_rst_n,
   bcd_mult_sched_if.slave bus
);

   typedef enum logic [1:0] {IDLE, MULT, CONV, OUT} state_t;

   state_t          state, state_nxt;
   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  win_id;
   logic [NREQ-1:0] win_vec;
   logic            any_req;
   logic [7:0]      a_arr [NREQ];
   logic [7:0]      b_arr [NREQ];
   logic [7:0]      op_a, op_b;
   logic [IDW-1:0]  job_id;
   logic [15:0]     prod_sh;
   logic [15:0]     acc, acc_nxt;
   logic [3:0]      cnt;
   logic [15:0]     res_bcd_q;
   logic [IDW-1:0]  res_id_q;
   logic [15:0]     res_load;

   function automatic logic [7:0] bcd2bin(input logic [7:0] v);
      return ({4'd0, v[7:4]} << 3) + ({4'd0, v[7:4]} << 1) + {4'd0, v[3:0]};
   endfunction

   function automatic logic [15:0] dabble_step(input logic [15:0] a, input logic b);
      logic [15:0] t;
      t = a;
      for (int n = 0; n < 4; n++) begin
         if (a[4*n +: 4] > 4'd4) t[4*n +: 4] = a[4*n +: 4] + 4'd3;
      end
      return {t[14:0], b};
   endfunction

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign a_arr[g] = bus.a_bcd[8*g +: 8];
      assign b_arr[g] = bus.b_bcd[8*g +: 8];
   end

   // first set request after the pointer, wrapping
   always_comb begin
      int idx_i;
      logic [IDW-1:0] idx;
      win_vec = '0;
      win_id  = '0;
      any_req = 1'b0;
      idx_i   = 0;
      idx     = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx_i = int'(ptr) + k;
         if (idx_i >= NREQ) idx_i = idx_i - NREQ;
         idx = IDW'(idx_i);
         if (!any_req && bus.req[idx]) begin
            any_req      = 1'b1;
            win_id       = idx;
            win_vec[idx] = 1'b1;
         end
      end
   end

   assign acc_nxt = dabble_step(acc, prod_sh[15]);

   always_ff @(posedge clock or negedge a_rst_n) begin
      if (!a_rst_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = MULT;
         MULT:    state_nxt = CONV;
         CONV:    if (cnt == 4'd15) state_nxt = OUT;
         OUT:     if (bus.res_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // grant is combinational from req, so it is held off explicitly during reset
   always_comb begin
      bus.gnt       = (state == IDLE && a_rst_n) ? win_vec : '0;
      bus.busy      = (state != IDLE);
      bus.res_valid = (state == OUT);
   end

   always_ff @(posedge clock or negedge a_rst_n) begin
      if (!a_rst_n) begin
         ptr       <= IDW'(NREQ - 1);
         op_a      <= '0;
         op_b      <= '0;
         job_id    <= '0;
         prod_sh   <= '0;
         acc       <= '0;
         cnt       <= '0;
         res_bcd_q <= '0;
         res_id_q  <= '0;
      end else begin
         case (state)
            IDLE: if (any_req) begin
               op_a   <= bcd2bin(a_arr[win_id]);
               op_b   <= bcd2bin(b_arr[win_id]);
               job_id <= win_id;
               ptr    <= win_id;
            end
            MULT: begin
               prod_sh <= 16'(op_a) * 16'(op_b);
               acc     <= '0;
               cnt     <= '0;
            end
            CONV: begin
               acc     <= acc_nxt;
               prod_sh <= prod_sh << 1;
               cnt     <= cnt + 4'd1;
               if (cnt == 4'd15) begin
                  res_bcd_q <= res_load;
                  res_id_q  <= job_id;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.res_bcd = res_bcd_q;
   assign bus.res_id  = res_id_q;

`ifdef BCD_MULT_SCHED_BCD_CHECK_EN
   logic bad_digit, job_err, res_err_q;

   always_comb begin
      bad_digit = (a_arr[win_id][7:4] > 4'd9) || (a_arr[win_id][3:0] > 4'd9) ||
                  (b_arr[win_id][7:4] > 4'd9) || (b_arr[win_id][3:0] > 4'd9);
   end

   always_ff @(posedge clock or negedge a_rst_n) begin
      if (!a_rst_n) begin
         job_err   <= 1'b0;
         res_err_q <= 1'b0;
      end else begin
         if (state == IDLE && any_req) job_err <= bad_digit;
         if (state == CONV && cnt == 4'd15) res_err_q <= job_err;
      end
   end

   // a bad job keeps its full timing but reports zero
   assign res_load    = job_err ? 16'h0000 : acc_nxt;
   assign bus.res_err = res_err_q;
`else
   assign res_load    = acc_nxt;
   assign bus.res_err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_mult_sched.sv
// Randomized self-checking bench for bcd_mult_sched: a latency/arithmetic reference model
// checked every cycle, plus directed jobs with hand-computed results.
module tb_bcd_mult_sched;
   localparam int NREQ = 4;
   localparam int IDW  = $clog2(NREQ);

   logic clock;
   logic a_rst_n;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   logic [7:0] ta  [NREQ];
   logic [7:0] tbb [NREQ];

   bcd_mult_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

   bcd_mult_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clock   (clock),
      .a_rst_n (a_rst_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   always_comb begin
      bus.a_bcd = '0;
      bus.b_bcd = '0;
      for (int i = 0; i < NREQ; i++) begin
         bus.a_bcd[i*8 +: 8] = ta[i];
         bus.b_bcd[i*8 +: 8] = tbb[i];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // {err, bcd} from plain decimal arithmetic
   function automatic logic [16:0] job_result(input logic [7:0] a, input logic [7:0] b);
      int va, vb, p;
      logic [15:0] r;
`ifdef BCD_MULT_SCHED_BCD_CHECK_EN
      if (a[7:4] > 9 || a[3:0] > 9 || b[7:4] > 9 || b[3:0] > 9) return {1'b1, 16'h0000};
`endif
      va = int'(a[7:4]) * 10 + int'(a[3:0]);
      vb = int'(b[7:4]) * 10 + int'(b[3:0]);
      p  = va * vb;
      r  = 16'(((p / 1000) % 10) << 12 | ((p / 100) % 10) << 8 | ((p / 10) % 10) << 4 | (p % 10));
      return {1'b0, r};
   endfunction

   function automatic int arb_idx(input logic [NREQ-1:0] r, input int p);
      for (int k = 1; k <= NREQ; k++) begin
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   // reference model: m_age counts cycles since grant (0 = idle, 18 = result offered)
   int          m_age = 0;
   int          m_ptr = NREQ - 1;
   int          j_id = 0;
   logic [16:0] j_res = '0;
   logic [15:0] m_res = '0;
   int          m_res_id = 0;
   logic        m_res_err = 1'b0;

   always @(negedge clock) begin
      int w;
      logic [NREQ-1:0] exp_gnt;
      if (!a_rst_n) begin
         chk("rst_gnt", 32'(bus.gnt), 0);
         chk("rst_busy", 32'(bus.busy), 0);
         chk("rst_valid", 32'(bus.res_valid), 0);
         chk("rst_bcd", 32'(bus.res_bcd), 0);
         chk("rst_id", 32'(bus.res_id), 0);
         chk("rst_err", 32'(bus.res_err), 0);
         m_age = 0; m_ptr = NREQ - 1; m_res = '0; m_res_id = 0; m_res_err = 1'b0;
      end else begin
         w = arb_idx(bus.req, m_ptr);
         exp_gnt = (m_age == 0 && w >= 0) ? NREQ'(1) << w : '0;
         chk("gnt", 32'(bus.gnt), 32'(exp_gnt));
         chk("busy", 32'(bus.busy), 32'(m_age != 0));
         chk("res_valid", 32'(bus.res_valid), 32'(m_age == 18));
         chk("res_bcd", 32'(bus.res_bcd), 32'(m_res));
         chk("res_id", 32'(bus.res_id), 32'(m_res_id));
         chk("res_err", 32'(bus.res_err), 32'(m_res_err));
         if (m_age == 0) begin
            if (w >= 0) begin
               m_ptr = w;
               j_id  = w;
               j_res = job_result(ta[w], tbb[w]);
               m_age = 1;
            end
         end else if (m_age < 17) begin
            m_age++;
         end else if (m_age == 17) begin
            m_age     = 18;
            m_res     = j_res[15:0];
            m_res_err = j_res[16];
            m_res_id  = j_id;
         end else if (bus.res_ready) begin
            m_age = 0;
         end
      end
   end

   task automatic do_reset();
      @(posedge clock); #1;
      a_rst_n = 1'b0;
      repeat (2) @(posedge clock);
      #1 a_rst_n = 1'b1;
   endtask

   task automatic wait_gnt(output int n);
      n = 0;
      while (n < 60) begin
         @(negedge clock);
         if (bus.gnt != 0) break;
         n++;
      end
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!bus.res_valid && n < 60);
   endtask

   task automatic drain();
      int n;
      bus.req = '0;
      bus.res_ready = 1'b1;
      n = 0;
      while (n < 60) begin
         @(negedge clock);
         if (!bus.busy) break;
         n++;
      end
      chk("drain_idle", 32'(bus.busy), 0);
      @(posedge clock); #1;
   endtask

   task automatic do_job(input int idx, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp_bcd, input logic exp_err);
      int n;
      ta[idx] = a; tbb[idx] = b;
      bus.res_ready = 1'b1;
      bus.req = NREQ'(1) << idx;
      wait_gnt(n);
      chk("job_gnt", 32'(bus.gnt), 32'(NREQ'(1) << idx));
      @(posedge clock); #1 bus.req = '0;
      wait_valid(n);
      chk("job_latency", n, 18);
      chk("job_bcd", 32'(bus.res_bcd), 32'(exp_bcd));
      chk("job_id", 32'(bus.res_id), idx);
      chk("job_err", 32'(bus.res_err), 32'(exp_err));
      @(posedge clock); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, last;
      logic [15:0] held;
      for (int i = 0; i < NREQ; i++) begin ta[i] = 8'h00; tbb[i] = 8'h00; end
      bus.req = '0;
      bus.res_ready = 1'b1;
      a_rst_n = 1'b1;
      #2 a_rst_n = 1'b0;
      repeat (2) @(posedge clock);
      #1 a_rst_n = 1'b1;

      chk("model_63x02", 32'(job_result(8'h63, 8'h02)), 32'h0_0126);
      chk("model_99x99", 32'(job_result(8'h99, 8'h99)), 32'h0_9801);
      chk("model_45x12", 32'(job_result(8'h45, 8'h12)), 32'h0_0540);

      do_job(0, 8'h63, 8'h02, 16'h0126, 1'b0);
      do_job(0, 8'h99, 8'h99, 16'h9801, 1'b0);
      do_job(0, 8'h00, 8'h57, 16'h0000, 1'b0);
      do_job(0, 8'h10, 8'h10, 16'h0100, 1'b0);

      // round robin with all four requesting
      do_reset();
      for (int i = 0; i < NREQ; i++) begin ta[i] = 8'h10 + 8'(i); tbb[i] = 8'h02; end
      bus.req = '1;
      last = 0;
      for (int g = 0; g < 5; g++) begin
         wait_gnt(n);
         chk("rr_gnt", 32'(bus.gnt), 32'(NREQ'(1) << (g % NREQ)));
         if (g > 0) chk("rr_spacing", cyc - last, 19);
         last = cyc;
         if (g == 4) begin @(posedge clock); #1 bus.req = '0; end
         wait_valid(n);
         chk("rr_bcd", 32'(bus.res_bcd), 32'h20 + 32'(2 * (g % NREQ)));
         chk("rr_id", 32'(bus.res_id), g % NREQ);
      end
      drain();

      // backpressure with requester 1 pending
      ta[0] = 8'h21; tbb[0] = 8'h03;
      ta[1] = 8'h11; tbb[1] = 8'h11;
      bus.res_ready = 1'b0;
      bus.req = 4'b0001;
      wait_gnt(n);
      chk("bp_gnt0", 32'(bus.gnt), 1);
      @(posedge clock); #1 bus.req = 4'b0010;
      wait_valid(n);
      held = bus.res_bcd;
      chk("bp_bcd", 32'(held), 32'h0063);
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         chk("bp_valid", 32'(bus.res_valid), 1);
         chk("bp_stable", 32'(bus.res_bcd), 32'h0063);
         chk("bp_id", 32'(bus.res_id), 0);
         chk("bp_gnt", 32'(bus.gnt), 0);
         chk("bp_busy", 32'(bus.busy), 1);
      end
      @(posedge clock); #1 bus.res_ready = 1'b1;
      @(negedge clock);
      @(negedge clock);
      chk("bp_gnt1", 32'(bus.gnt), 2);
      @(posedge clock); #1 bus.req = '0;
      wait_valid(n);
      chk("bp_bcd1", 32'(bus.res_bcd), 32'h0121);
      chk("bp_id1", 32'(bus.res_id), 1);
      drain();

      // reset in the middle of a job
      ta[0] = 8'h45; tbb[0] = 8'h12;
      bus.req = 4'b0001;
      wait_gnt(n);
      chk("mr_gnt", 32'(bus.gnt), 1);
      repeat (10) @(posedge clock);
      #1 a_rst_n = 1'b0;
      #1;
      chk("mr_gnt0", 32'(bus.gnt), 0);
      chk("mr_busy0", 32'(bus.busy), 0);
      chk("mr_valid0", 32'(bus.res_valid), 0);
      chk("mr_bcd0", 32'(bus.res_bcd), 0);
      chk("mr_id0", 32'(bus.res_id), 0);
      bus.req = '0;
      repeat (2) @(posedge clock);
      #1 a_rst_n = 1'b1;
      ta[1] = 8'h03; tbb[1] = 8'h03;
      ta[2] = 8'h04; tbb[2] = 8'h04;
      bus.req = 4'b0110;
      wait_gnt(n);
      chk("mr_ptr", 32'(bus.gnt), 2);
      @(posedge clock); #1 bus.req = '0;
      drain();
      do_job(0, 8'h45, 8'h12, 16'h0540, 1'b0);

`ifdef BCD_MULT_SCHED_BCD_CHECK_EN
      do_job(0, 8'h5A, 8'h01, 16'h0000, 1'b1);
`else
      do_job(0, 8'h5A, 8'h01, 16'h0060, 1'b0);
`endif

      // random traffic, checked by the model every cycle
      for (int c = 0; c < 1500; c++) begin
         @(posedge clock); #1;
         a_rst_n = ($urandom_range(0, 299) != 0);
         for (int i = 0; i < NREQ; i++) begin
            bus.req[i] = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 4) != 0) begin
               ta[i]  = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
               tbb[i] = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            end else begin
               ta[i]  = 8'($urandom);
               tbb[i] = 8'($urandom);
            end
         end
         bus.res_ready = ($urandom_range(0, 99) < 70);
      end
      @(posedge clock); #1 a_rst_n = 1'b1;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
